// File: rtl/dmem_sized_port.sv
// Byte-addressed synchronous data memory with sized loads/stores, valid/ready
// request handshake and LATENCY-cycle response. Optional macro: DMEM_MISALIGN_TRAP_EN.
module dmem_sized_port #(
    parameter int DEPTH   = 1024,
    parameter int ADDR_W  = 32,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int         IDX_W    = $clog2(DEPTH);
    localparam int         CNT_INIT = (LATENCY > 1) ? (LATENCY - 2) : 0;
    localparam logic [1:0] CNT_LOAD = CNT_INIT[1:0];
    localparam bit         LAT_ONE  = (LATENCY == 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] m;
        case (size)
            2'b00:   m = 4'b0001 << off;
            2'b01:   m = off[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                                 input logic uns, input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   r = uns ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   r = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    logic [31:0]      mem_r [0:DEPTH-1];
    state_t           state_r, state_next_s;
    logic [1:0]       cnt_r, cnt_next_s;
    logic             req_ready_r, rsp_valid_r, rsp_err_r;
    logic [31:0]      rsp_rdata_r, pend_rdata_r;
    logic             pend_err_r;
    logic             accept_s, mis_s;
    logic [1:0]       off_s;
    logic [3:0]       mask_s;
    logic [31:0]      wlanes_s, ext_s;
    logic [IDX_W-1:0] idx_s;
    logic             unused_addr_s;

    assign unused_addr_s = ^req_addr[ADDR_W-1:IDX_W+2];
    assign accept_s      = req_valid && req_ready_r;
    assign idx_s         = req_addr[IDX_W+1:2];

    // Effective lane offset and misalignment classification
    always_comb begin
        mis_s = 1'b0;
        off_s = req_addr[1:0];
`ifdef DMEM_MISALIGN_TRAP_EN
        mis_s = ((req_size == 2'b01) && req_addr[0]) || (req_size[1] && (req_addr[1:0] != 2'b00));
`else
        case (req_size)
            2'b00:   off_s = req_addr[1:0];
            2'b01:   off_s = {req_addr[1], 1'b0};
            default: off_s = 2'b00;
        endcase
`endif
    end

    // Store lane enables/data replication and load result for the presented request
    always_comb begin
        mask_s = mis_s ? 4'b0000 : lane_mask(req_size, off_s);
        case (req_size)
            2'b00:   wlanes_s = {4{req_wdata[7:0]}};
            2'b01:   wlanes_s = {2{req_wdata[15:0]}};
            default: wlanes_s = req_wdata;
        endcase
        if (req_we || mis_s) begin
            ext_s = 32'd0;
        end else begin
            ext_s = load_extract(mem_r[idx_s], req_size, req_unsigned, off_s);
        end
    end

    // Storage array: contents are not reset; stores merge enabled lanes at accept
    always_ff @(posedge clk) begin
        if (accept_s && req_we) begin
            for (int i = 0; i < 4; i++) begin
                if (mask_s[i]) begin
                    mem_r[idx_s][8*i +: 8] <= wlanes_s[8*i +: 8];
                end
            end
        end
    end

    // FSM state and latency counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= 2'd0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // FSM next-state and counter logic
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (LAT_ONE) begin
                        state_next_s = ST_RESP;
                    end else begin
                        state_next_s = ST_WAIT;
                        cnt_next_s   = CNT_LOAD;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 2'd0) begin
                    state_next_s = ST_RESP;
                end else begin
                    cnt_next_s = cnt_r - 2'd1;
                end
            end
            ST_RESP: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Registered handshake/response outputs; result is computed at accept and
    // published on entry to RESP so it holds until the next response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready_r  <= 1'b1;
            rsp_valid_r  <= 1'b0;
            rsp_rdata_r  <= 32'd0;
            rsp_err_r    <= 1'b0;
            pend_rdata_r <= 32'd0;
            pend_err_r   <= 1'b0;
        end else begin
            req_ready_r <= (state_next_s == ST_IDLE);
            rsp_valid_r <= (state_next_s == ST_RESP);
            if (accept_s) begin
                pend_rdata_r <= ext_s;
                pend_err_r   <= mis_s;
            end
            if (state_next_s == ST_RESP) begin
                rsp_rdata_r <= (state_r == ST_IDLE) ? ext_s : pend_rdata_r;
                rsp_err_r   <= (state_r == ST_IDLE) ? mis_s : pend_err_r;
            end
        end
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_dmem_sized_port.sv
// Directed self-checking bench: instance 0 uses LATENCY=1, instance 1 LATENCY=3.
module tb_dmem_sized_port;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [1:0]      req_valid, req_we, req_unsigned, req_ready, rsp_valid, rsp_err;
    logic [1:0][1:0] req_size;
    logic [1:0][31:0] req_addr, req_wdata, rsp_rdata;

    int checks = 0;
    int errors = 0;

    dmem_sized_port #(.DEPTH(1024), .ADDR_W(32), .LATENCY(1)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_size(req_size[0]), .req_unsigned(req_unsigned[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_err(rsp_err[0])
    );

    dmem_sized_port #(.DEPTH(1024), .ADDR_W(32), .LATENCY(3)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_size(req_size[1]), .req_unsigned(req_unsigned[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_err(rsp_err[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // One access on instance d with latency lat: checks response timing, data, error and hold
    task automatic acc(input int d, input int lat, input logic we, input logic [1:0] sz,
                       input logic uns, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_d, input logic exp_e, input string tag);
        @(negedge clk);
        check({tag, " ready"}, {31'd0, req_ready[d]}, 32'd1);
        req_valid[d] = 1'b1; req_we[d] = we; req_size[d] = sz;
        req_unsigned[d] = uns; req_addr[d] = a; req_wdata[d] = wd;
        @(posedge clk);
        #1 req_valid[d] = 1'b0;
        for (int k = 1; k < lat; k++) begin
            @(negedge clk);
            check({tag, " early"}, {31'd0, rsp_valid[d]}, 32'd0);
        end
        @(negedge clk);
        check({tag, " valid"}, {31'd0, rsp_valid[d]}, 32'd1);
        check({tag, " rdata"}, rsp_rdata[d], exp_d);
        check({tag, " err"}, {31'd0, rsp_err[d]}, {31'd0, exp_e});
        @(negedge clk);
        check({tag, " pulse"}, {31'd0, rsp_valid[d]}, 32'd0);
        check({tag, " hold"}, rsp_rdata[d], exp_d);
    endtask

    logic [31:0] mis_word, mis_half;
    logic        mis_err;
    int          seen;

    initial begin
        rst_n = 1'b0;
        req_valid = '0; req_we = '0; req_unsigned = '0;
        req_size = '0; req_addr = '0; req_wdata = '0;
        repeat (2) @(negedge clk);
        check("rst ready", {31'd0, req_ready[0]}, 32'd1);
        check("rst valid", {31'd0, rsp_valid[0]}, 32'd0);
        check("rst rdata", rsp_rdata[0], 32'd0);
        check("rst err", {31'd0, rsp_err[0]}, 32'd0);
        rst_n = 1'b1;

        acc(0, 1, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, "st_w10");
        acc(0, 1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "ld_w10");
        acc(0, 1, 1'b1, 2'b00, 1'b0, 32'h13, 32'h00000080, 32'h0, 1'b0, "st_b13");
        acc(0, 1, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0, "ld_bs13");
        acc(0, 1, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'h00000080, 1'b0, "ld_bu13");
        acc(0, 1, 1'b0, 2'b10, 1'b1, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0, "ld_w10b");
        acc(0, 1, 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 32'hFFFFFFBE, 1'b0, "ld_bs11");
        acc(0, 1, 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 32'hFFFFBEEF, 1'b0, "ld_hs10");
        acc(0, 1, 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 32'h0000BEEF, 1'b0, "ld_hu10");
        acc(0, 1, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'hFFFF80AD, 1'b0, "ld_hs12");
        acc(0, 1, 1'b1, 2'b10, 1'b0, 32'h20, 32'h55667788, 32'h0, 1'b0, "st_w20");
        acc(0, 1, 1'b1, 2'b01, 1'b0, 32'h22, 32'hFFFF1234, 32'h0, 1'b0, "st_h22");
        acc(0, 1, 1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 32'h00001234, 1'b0, "ld_hs22");
        acc(0, 1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h12347788, 1'b0, "ld_w20");
        acc(0, 1, 1'b1, 2'b10, 1'b0, 32'h1000, 32'hA5A5A5A5, 32'h0, 1'b0, "st_wrap");
        acc(0, 1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'hA5A5A5A5, 1'b0, "ld_wrap");

`ifdef DMEM_MISALIGN_TRAP_EN
        mis_err = 1'b1; mis_word = 32'h12347788; mis_half = 32'h0;
`else
        mis_err = 1'b0; mis_word = 32'h11111111; mis_half = 32'hFFFFBEEF;
`endif
        acc(0, 1, 1'b1, 2'b10, 1'b0, 32'h21, 32'h11111111, 32'h0, mis_err, "st_mis21");
        acc(0, 1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, mis_word, 1'b0, "ld_w20m");
        acc(0, 1, 1'b0, 2'b01, 1'b0, 32'h11, 32'h0, mis_half, mis_err, "ld_mis11");

        // Back-to-back stores with req_valid held on the LATENCY=3 instance
        @(negedge clk);
        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_size[1] = 2'b10;
        req_addr[1] = 32'h40; req_wdata[1] = 32'h0BADF00D;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            check($sformatf("l3 ready c%0d", i), {31'd0, req_ready[1]}, {31'd0, (i % 4) == 0});
            check($sformatf("l3 valid c%0d", i), {31'd0, rsp_valid[1]}, {31'd0, (i % 4) == 3});
        end
        req_valid[1] = 1'b0;
        acc(1, 3, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h0BADF00D, 1'b0, "l3 ld40");

        // Reset during WAIT: response dropped, accepted store kept
        @(negedge clk);
        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_size[1] = 2'b10;
        req_addr[1] = 32'h44; req_wdata[1] = 32'h77777777;
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        @(negedge clk);
        check("wait ready", {31'd0, req_ready[1]}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("rstmid ready", {31'd0, req_ready[1]}, 32'd1);
        check("rstmid valid", {31'd0, rsp_valid[1]}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rsp_valid[1]) seen++;
        end
        check("rstmid no rsp", 32'(seen), 32'd0);
        check("rstmid ready after", {31'd0, req_ready[1]}, 32'd1);
        acc(1, 3, 1'b0, 2'b10, 1'b0, 32'h44, 32'h0, 32'h77777777, 1'b0, "l3 ld44");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
